// File: rtl/tile_xy_hop_router.sv
// One tile's router for a single mesh dimension: forwards packets up/down the
// line, ejects packets addressed to this tile and injects local traffic.

module tile_xy_hop_fifo #(
  parameter int W        = 8,
  parameter int DEPTH    = 8,
  parameter int AF_LEVEL = 6
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push_i,
  input  logic [W-1:0] wdata_i,
  input  logic         pop_i,
  output logic [W-1:0] rdata_o,
  output logic         empty_o,
  output logic         full_o,
  output logic         af_o
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_C = DEPTH[AW:0];
  localparam logic [AW:0] AF_C    = AF_LEVEL[AW:0];

  logic [W-1:0] mem_q [DEPTH];
  logic [AW:0]  wrPtr_q, wrPtr_d, rdPtr_q, rdPtr_d;
  logic [AW:0]  occ;
  logic         doPush, doPop;

  // The extra pointer bit separates a full FIFO from an empty one.
  always_comb begin
    occ     = wrPtr_q - rdPtr_q;
    empty_o = (occ == '0);
    full_o  = (occ == DEPTH_C);
    af_o    = (occ >= AF_C);
    doPush  = push_i && !full_o;
    doPop   = pop_i && !empty_o;
    wrPtr_d = doPush ? wrPtr_q + 1'b1 : wrPtr_q;
    rdPtr_d = doPop ? rdPtr_q + 1'b1 : rdPtr_q;
    rdata_o = mem_q[rdPtr_q[AW-1:0]];
  end

  // Pointer registers; a reset empties the queue at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
    end else begin
      wrPtr_q <= wrPtr_d;
      rdPtr_q <= rdPtr_d;
    end
  end

  // Payload storage carries no reset; the pointers alone define validity.
  always_ff @(posedge clk) begin
    if (doPush) mem_q[wrPtr_q[AW-1:0]] <= wdata_i;
  end
endmodule

module tile_xy_hop_router #(
  parameter int TILE_C   = 0,
  parameter int DIM      = 0,
  parameter int CW       = 5,
  parameter int DW       = 592,
  parameter int DEPTH    = 8,
  parameter int AF_LEVEL = 6
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               up_in_valid,
  output logic               up_in_ready,
  input  logic [2*CW+DW-1:0] up_in_pkt,
  input  logic               dn_in_valid,
  output logic               dn_in_ready,
  input  logic [2*CW+DW-1:0] dn_in_pkt,
  output logic               up_out_valid,
  input  logic               up_out_ready,
  output logic [2*CW+DW-1:0] up_out_pkt,
  output logic               dn_out_valid,
  input  logic               dn_out_ready,
  output logic [2*CW+DW-1:0] dn_out_pkt,
  input  logic               inj_valid,
  output logic               inj_ready,
  input  logic [2*CW+DW-1:0] inj_pkt,
  output logic               ej_valid,
  input  logic               ej_ready,
  output logic [2*CW+DW-1:0] ej_pkt,
  output logic [2:0]         af,
  output logic               err
);
  localparam int PW = 2*CW + DW;
  localparam logic [CW-1:0] TC = TILE_C[CW-1:0];

  logic [PW-1:0] upWdata, dnWdata, ejWdata;
  logic upPush, dnPush, ejPush;
  logic upFull, dnFull, ejFull, upEmpty, dnEmpty, ejEmpty;
  logic upAf, dnAf, ejAf;
  logic [CW-1:0] upTc, dnTc, injTc;
  logic upToEj, upToUp, upWrong, dnToEj, dnToDn, dnWrong;
  logic injToUp, injToDn, injToEj;
  logic gUpPass, gUpInj, gDnPass, gDnInj, gEjUp, gEjDn, gEjInj;
  logic upRr_q, upRr_d, dnRr_q, dnRr_d, err_q, err_d;
  logic [1:0] ejRr_q, ejRr_d;

  function automatic logic [CW-1:0] tcOf(input logic [PW-1:0] p);
    return (DIM != 0) ? p[PW-1 -: CW] : p[PW-CW-1 -: CW];
  endfunction

  // Decode routes, arbitrate each FIFO's write port and derive handshakes.
  always_comb begin
    upTc    = tcOf(up_in_pkt);
    dnTc    = tcOf(dn_in_pkt);
    injTc   = tcOf(inj_pkt);
    upToEj  = up_in_valid && (upTc == TC);
    upToUp  = up_in_valid && (upTc > TC);
    upWrong = up_in_valid && (upTc < TC);
    dnToEj  = dn_in_valid && (dnTc == TC);
    dnToDn  = dn_in_valid && (dnTc < TC);
    dnWrong = dn_in_valid && (dnTc > TC);
    injToUp = inj_valid && (injTc > TC);
    injToDn = inj_valid && (injTc < TC);
    injToEj = inj_valid && (injTc == TC);

    gUpPass = upToUp && (!injToUp || !upRr_q);
    gUpInj  = injToUp && (!upToUp || upRr_q);
    gDnPass = dnToDn && (!injToDn || !dnRr_q);
    gDnInj  = injToDn && (!dnToDn || dnRr_q);

    gEjUp  = 1'b0;
    gEjDn  = 1'b0;
    gEjInj = 1'b0;
    case (ejRr_q)
      2'd1: begin
        if (dnToEj) gEjDn = 1'b1;
        else if (injToEj) gEjInj = 1'b1;
        else if (upToEj) gEjUp = 1'b1;
      end
      2'd2: begin
        if (injToEj) gEjInj = 1'b1;
        else if (upToEj) gEjUp = 1'b1;
        else if (dnToEj) gEjDn = 1'b1;
      end
      default: begin
        if (upToEj) gEjUp = 1'b1;
        else if (dnToEj) gEjDn = 1'b1;
        else if (injToEj) gEjInj = 1'b1;
      end
    endcase

    upPush  = (gUpPass || gUpInj) && !upFull;
    dnPush  = (gDnPass || gDnInj) && !dnFull;
    ejPush  = (gEjUp || gEjDn || gEjInj) && !ejFull;
    upWdata = gUpInj ? inj_pkt : up_in_pkt;
    dnWdata = gDnInj ? inj_pkt : dn_in_pkt;
    ejWdata = gEjInj ? inj_pkt : (gEjDn ? dn_in_pkt : up_in_pkt);

    up_in_ready = upWrong || (gUpPass && !upFull) || (gEjUp && !ejFull);
    dn_in_ready = dnWrong || (gDnPass && !dnFull) || (gEjDn && !ejFull);
    inj_ready   = (gUpInj && !upFull) || (gDnInj && !dnFull) || (gEjInj && !ejFull);

    upRr_d = upPush ? gUpPass : upRr_q;
    dnRr_d = dnPush ? gDnPass : dnRr_q;
    ejRr_d = ejRr_q;
    if (ejPush) ejRr_d = gEjUp ? 2'd1 : (gEjDn ? 2'd2 : 2'd0);
    err_d = err_q || upWrong || dnWrong;
  end

  // Round-robin pointers and the sticky wrong-direction flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      upRr_q <= 1'b0;
      dnRr_q <= 1'b0;
      ejRr_q <= 2'd0;
      err_q  <= 1'b0;
    end else begin
      upRr_q <= upRr_d;
      dnRr_q <= dnRr_d;
      ejRr_q <= ejRr_d;
      err_q  <= err_d;
    end
  end

  tile_xy_hop_fifo #(.W(PW), .DEPTH(DEPTH), .AF_LEVEL(AF_LEVEL)) uUpq (
    .clk(clk), .rst(rst), .push_i(upPush), .wdata_i(upWdata),
    .pop_i(up_out_ready), .rdata_o(up_out_pkt), .empty_o(upEmpty),
    .full_o(upFull), .af_o(upAf)
  );

  tile_xy_hop_fifo #(.W(PW), .DEPTH(DEPTH), .AF_LEVEL(AF_LEVEL)) uDnq (
    .clk(clk), .rst(rst), .push_i(dnPush), .wdata_i(dnWdata),
    .pop_i(dn_out_ready), .rdata_o(dn_out_pkt), .empty_o(dnEmpty),
    .full_o(dnFull), .af_o(dnAf)
  );

  tile_xy_hop_fifo #(.W(PW), .DEPTH(DEPTH), .AF_LEVEL(AF_LEVEL)) uEjq (
    .clk(clk), .rst(rst), .push_i(ejPush), .wdata_i(ejWdata),
    .pop_i(ej_ready), .rdata_o(ej_pkt), .empty_o(ejEmpty),
    .full_o(ejFull), .af_o(ejAf)
  );

  assign up_out_valid = !upEmpty;
  assign dn_out_valid = !dnEmpty;
  assign ej_valid     = !ejEmpty;
  assign af           = {ejAf, dnAf, upAf};
  assign err          = err_q;
endmodule

// File: tb/tb_tile_xy_hop_router.sv
// Scoreboard bench for tile_xy_hop_router at tile coordinate 4 on the X axis.

module tb_tile_xy_hop_router;
  localparam int TILE_C = 4;
  localparam int CW = 5;
  localparam int DW = 32;
  localparam int DEPTH = 8;
  localparam int AF_LEVEL = 6;
  localparam int PW = 2*CW + DW;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic up_in_valid = 0, up_in_ready;
  logic [PW-1:0] up_in_pkt = '0;
  logic dn_in_valid = 0, dn_in_ready;
  logic [PW-1:0] dn_in_pkt = '0;
  logic up_out_valid, up_out_ready = 0;
  logic [PW-1:0] up_out_pkt;
  logic dn_out_valid, dn_out_ready = 0;
  logic [PW-1:0] dn_out_pkt;
  logic inj_valid = 0, inj_ready;
  logic [PW-1:0] inj_pkt = '0;
  logic ej_valid, ej_ready = 0;
  logic [PW-1:0] ej_pkt;
  logic [2:0] af;
  logic err;

  int checks = 0;
  int errors = 0;
  logic [PW-1:0] upExp[$];
  logic [PW-1:0] dnExp[$];
  logic [PW-1:0] ejExp[$];

  tile_xy_hop_router #(.TILE_C(TILE_C), .DIM(0), .CW(CW), .DW(DW),
                       .DEPTH(DEPTH), .AF_LEVEL(AF_LEVEL)) dut (
    .clk(clk), .rst(rst),
    .up_in_valid(up_in_valid), .up_in_ready(up_in_ready), .up_in_pkt(up_in_pkt),
    .dn_in_valid(dn_in_valid), .dn_in_ready(dn_in_ready), .dn_in_pkt(dn_in_pkt),
    .up_out_valid(up_out_valid), .up_out_ready(up_out_ready), .up_out_pkt(up_out_pkt),
    .dn_out_valid(dn_out_valid), .dn_out_ready(dn_out_ready), .dn_out_pkt(dn_out_pkt),
    .inj_valid(inj_valid), .inj_ready(inj_ready), .inj_pkt(inj_pkt),
    .ej_valid(ej_valid), .ej_ready(ej_ready), .ej_pkt(ej_pkt),
    .af(af), .err(err)
  );

  // Free-running clock, rising edges at 5, 15, 25, ...
  always #5 clk = ~clk;

  function automatic logic [PW-1:0] mk(input logic [CW-1:0] ty, input logic [CW-1:0] tx,
                                       input logic [DW-1:0] pl);
    return {ty, tx, pl};
  endfunction

  // Destination from the routing rules: 0 up, 1 dn, 2 eject, 3 dropped.
  function automatic int destOf(input logic [PW-1:0] p, input int src);
    int tc;
    tc = int'(p[PW-CW-1 -: CW]);
    if (tc == TILE_C) return 2;
    if (src == 0) return (tc > TILE_C) ? 0 : 3;
    if (src == 1) return (tc < TILE_C) ? 1 : 3;
    return (tc > TILE_C) ? 0 : 1;
  endfunction

  task automatic pushExp(input int d, input logic [PW-1:0] p);
    case (d)
      0: upExp.push_back(p);
      1: dnExp.push_back(p);
      2: ejExp.push_back(p);
      default: ;
    endcase
  endtask

  // Scoreboard: checks pops against expected order, then records accepted pushes.
  always begin
    logic [PW-1:0] e;
    @(negedge clk);
    #2;
    if (!rst) begin
      if (up_out_valid && up_out_ready) begin
        checks++;
        if (upExp.size() == 0) begin
          errors++;
          $display("[TB] FAIL up_out_extra got %h required none", up_out_pkt);
        end else begin
          e = upExp.pop_front();
          if (up_out_pkt !== e) begin
            errors++;
            $display("[TB] FAIL up_out_pkt got %h required %h", up_out_pkt, e);
          end
        end
      end
      if (dn_out_valid && dn_out_ready) begin
        checks++;
        if (dnExp.size() == 0) begin
          errors++;
          $display("[TB] FAIL dn_out_extra got %h required none", dn_out_pkt);
        end else begin
          e = dnExp.pop_front();
          if (dn_out_pkt !== e) begin
            errors++;
            $display("[TB] FAIL dn_out_pkt got %h required %h", dn_out_pkt, e);
          end
        end
      end
      if (ej_valid && ej_ready) begin
        checks++;
        if (ejExp.size() == 0) begin
          errors++;
          $display("[TB] FAIL ej_extra got %h required none", ej_pkt);
        end else begin
          e = ejExp.pop_front();
          if (ej_pkt !== e) begin
            errors++;
            $display("[TB] FAIL ej_pkt got %h required %h", ej_pkt, e);
          end
        end
      end
      if (up_in_valid && destOf(up_in_pkt, 0) == 3) begin
        checks++;
        if (up_in_ready !== 1'b1) begin
          errors++;
          $display("[TB] FAIL up_wrong_ready got %b required 1", up_in_ready);
        end
      end
      if (dn_in_valid && destOf(dn_in_pkt, 1) == 3) begin
        checks++;
        if (dn_in_ready !== 1'b1) begin
          errors++;
          $display("[TB] FAIL dn_wrong_ready got %b required 1", dn_in_ready);
        end
      end
      if (up_in_valid && up_in_ready) pushExp(destOf(up_in_pkt, 0), up_in_pkt);
      if (dn_in_valid && dn_in_ready) pushExp(destOf(dn_in_pkt, 1), dn_in_pkt);
      if (inj_valid && inj_ready) pushExp(destOf(inj_pkt, 2), inj_pkt);
    end
  end

  task automatic doReset();
    rst = 1'b1;
    upExp.delete(); dnExp.delete(); ejExp.delete();
    up_in_valid = 0; dn_in_valid = 0; inj_valid = 0;
    up_out_ready = 0; dn_out_ready = 0; ej_ready = 0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic waitDrain(input int limit);
    int n = 0;
    up_in_valid = 0; dn_in_valid = 0; inj_valid = 0;
    up_out_ready = 1; dn_out_ready = 1; ej_ready = 1;
    while ((upExp.size() + dnExp.size() + ejExp.size()) != 0 && n < limit) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    #3;
    checks++;
    if ((upExp.size() + dnExp.size() + ejExp.size()) != 0 ||
        up_out_valid !== 1'b0 || dn_out_valid !== 1'b0 || ej_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL drain left %0d/%0d/%0d valid %b%b%b required empty",
               upExp.size(), dnExp.size(), ejExp.size(), up_out_valid, dn_out_valid, ej_valid);
    end
  endtask

  task automatic test_reset();
    doReset();
    #1;
    checks++;
    if ({up_out_valid, dn_out_valid, ej_valid, af, err} !== 7'b0) begin
      errors++;
      $display("[TB] FAIL reset_state got %b%b%b af=%b err=%b required all 0",
               up_out_valid, dn_out_valid, ej_valid, af, err);
    end
    checks++;
    if ({up_in_ready, dn_in_ready, inj_ready} !== 3'b000) begin
      errors++;
      $display("[TB] FAIL idle_ready got %b%b%b required 000", up_in_ready, dn_in_ready, inj_ready);
    end
  endtask

  task automatic test_inject();
    logic [PW-1:0] p;
    doReset();
    up_out_ready = 1;
    p = mk(5'd0, 5'd5, 32'hA5A5_0001);
    @(negedge clk);
    inj_valid = 1; inj_pkt = p;
    #1;
    checks++;
    if (inj_ready !== 1'b1) begin
      errors++;
      $display("[TB] FAIL inj_ready got %b required 1", inj_ready);
    end
    @(negedge clk);
    inj_valid = 0;
    #1;
    checks++;
    if (up_out_valid !== 1'b1 || up_out_pkt !== p || dn_out_valid !== 1'b0 || ej_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL inj_latency got v=%b pkt=%h dn=%b ej=%b required 1 %h 0 0",
               up_out_valid, up_out_pkt, dn_out_valid, ej_valid, p);
    end
    @(negedge clk);
    #1;
    checks++;
    if (up_out_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL inj_single got %b required 0", up_out_valid);
    end
  endtask

  task automatic test_fill_af();
    doReset();
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      up_in_valid = 1;
      up_in_pkt = mk(5'd0, 5'(6 + i % 3), 32'h1000 + i);
      #1;
      checks++;
      if (up_in_ready !== (i < DEPTH) || af[0] !== (i >= AF_LEVEL)) begin
        errors++;
        $display("[TB] FAIL fill_%0d got ready=%b af0=%b required %b %b",
                 i, up_in_ready, af[0], (i < DEPTH), (i >= AF_LEVEL));
      end
    end
    @(negedge clk);
    up_in_valid = 0;
    #1;
    checks++;
    if (af !== 3'b001 || up_out_valid !== 1'b1) begin
      errors++;
      $display("[TB] FAIL full_flags got af=%b v=%b required 001 1", af, up_out_valid);
    end
    waitDrain(20);
  endtask

  task automatic test_ej_rr();
    int pay[3];
    doReset();
    ej_ready = 1;
    pay = '{0, 0, 0};
    for (int k = 0; k < 9; k++) begin
      @(negedge clk);
      up_in_valid = 1; up_in_pkt = mk(5'd1, 5'd4, 32'h0A00 + pay[0]);
      dn_in_valid = 1; dn_in_pkt = mk(5'd2, 5'd4, 32'h0B00 + pay[1]);
      inj_valid = 1;   inj_pkt   = mk(5'd3, 5'd4, 32'h0C00 + pay[2]);
      #1;
      checks++;
      if ({up_in_ready, dn_in_ready, inj_ready} !== (3'b100 >> (k % 3))) begin
        errors++;
        $display("[TB] FAIL ej_rr_%0d got %b%b%b required %b", k,
                 up_in_ready, dn_in_ready, inj_ready, 3'b100 >> (k % 3));
      end
      if (up_in_ready) pay[0]++;
      if (dn_in_ready) pay[1]++;
      if (inj_ready) pay[2]++;
    end
    waitDrain(20);
  endtask

  task automatic test_up_rr();
    doReset();
    up_out_ready = 1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      up_in_valid = 1; up_in_pkt = mk(5'd0, 5'd7, 32'h2000 + k);
      inj_valid = 1;   inj_pkt   = mk(5'd0, 5'd7, 32'h3000 + k);
      #1;
      checks++;
      if (up_in_ready !== (k % 2 == 0) || inj_ready !== (k % 2 == 1)) begin
        errors++;
        $display("[TB] FAIL up_rr_%0d got pass=%b inj=%b required %b %b", k,
                 up_in_ready, inj_ready, (k % 2 == 0), (k % 2 == 1));
      end
    end
    waitDrain(20);
  endtask

  task automatic test_wrong_dir();
    doReset();
    @(negedge clk);
    up_in_valid = 1; up_in_pkt = mk(5'd9, 5'd2, 32'hDEAD_0001);
    #1;
    checks++;
    if (err !== 1'b0) begin
      errors++;
      $display("[TB] FAIL err_early got %b required 0", err);
    end
    @(negedge clk);
    up_in_valid = 0;
    #1;
    checks++;
    if (err !== 1'b1 || {up_out_valid, dn_out_valid, ej_valid} !== 3'b000 || af !== 3'b000) begin
      errors++;
      $display("[TB] FAIL wrong_dir got err=%b v=%b%b%b af=%b required 1 000 000",
               err, up_out_valid, dn_out_valid, ej_valid, af);
    end
    @(negedge clk);
    dn_in_valid = 1; dn_in_pkt = mk(5'd0, 5'd9, 32'hDEAD_0002);
    @(negedge clk);
    dn_in_valid = 0;
    repeat (3) @(negedge clk);
    #1;
    checks++;
    if (err !== 1'b1 || {up_out_valid, dn_out_valid, ej_valid} !== 3'b000) begin
      errors++;
      $display("[TB] FAIL err_sticky got err=%b v=%b%b%b required 1 000",
               err, up_out_valid, dn_out_valid, ej_valid);
    end
  endtask

  task automatic test_async_reset();
    logic [PW-1:0] p;
    doReset();
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      up_in_valid = 1; up_in_pkt = mk(5'd0, 5'd5, 32'h4000 + i);
    end
    @(negedge clk);
    up_in_valid = 0;
    #1;
    checks++;
    if (up_out_valid !== 1'b1 || af !== 3'b001) begin
      errors++;
      $display("[TB] FAIL prefill got v=%b af=%b required 1 001", up_out_valid, af);
    end
    #2;
    rst = 1'b1;
    upExp.delete(); dnExp.delete(); ejExp.delete();
    #1;
    checks++;
    if (up_out_valid !== 1'b0 || af !== 3'b000) begin
      errors++;
      $display("[TB] FAIL async_rst got v=%b af=%b required 0 000", up_out_valid, af);
    end
    @(negedge clk);
    rst = 1'b0;
    p = mk(5'd0, 5'd5, 32'h0000_BEEF);
    @(negedge clk);
    up_in_valid = 1; up_in_pkt = p;
    @(negedge clk);
    up_in_valid = 0;
    #1;
    checks++;
    if (up_out_valid !== 1'b1 || up_out_pkt !== p) begin
      errors++;
      $display("[TB] FAIL post_rst_head got v=%b pkt=%h required 1 %h", up_out_valid, up_out_pkt, p);
    end
    waitDrain(20);
  endtask

  task automatic test_random();
    doReset();
    for (int k = 0; k < 300; k++) begin
      @(negedge clk);
      up_in_valid = ($urandom_range(0, 1) == 1);
      up_in_pkt = mk(5'($urandom_range(0, 31)), 5'($urandom_range(0, 8)), $urandom());
      dn_in_valid = ($urandom_range(0, 1) == 1);
      dn_in_pkt = mk(5'($urandom_range(0, 31)), 5'($urandom_range(0, 8)), $urandom());
      inj_valid = ($urandom_range(0, 1) == 1);
      inj_pkt = mk(5'($urandom_range(0, 31)), 5'($urandom_range(0, 8)), $urandom());
      up_out_ready = ($urandom_range(0, 3) != 0);
      dn_out_ready = ($urandom_range(0, 3) != 0);
      ej_ready = ($urandom_range(0, 3) != 0);
    end
    waitDrain(60);
  endtask

  // Bound the whole run so a stuck design still ends with a report.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    test_reset();
    test_inject();
    test_fill_af();
    test_ej_rr();
    test_up_rr();
    test_wrong_dir();
    test_async_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
